// File: rtl/ascon_final_verify_if.sv
// Job/result handshake bundle between the ciphertext-absorb stage and ascon_final_verify.
interface ascon_final_verify_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] key0, key1;
  logic [63:0] tag0, tag1;
  logic        out_valid;
  logic        out_ready;
  logic        tag_ok;
  logic [63:0] t0, t1;
  logic        busy;

  modport master (
    output in_valid, x0, x1, x2, x3, x4, key0, key1, tag0, tag1, out_ready,
    input  in_ready, out_valid, tag_ok, t0, t1, busy
  );

  modport slave (
    input  in_valid, x0, x1, x2, x3, x4, key0, key1, tag0, tag1, out_ready,
    output in_ready, out_valid, tag_ok, t0, t1, busy
  );
endinterface

// File: rtl/ascon_final_verify.sv
// Decrypt-side ASCON finalization: key mix, p^NUM_ROUNDS, tag compute and constant-time compare.
// Define ASCON_FINAL_UNROLL2_EN to evaluate two permutation rounds per clock (identical results).
module ascon_final_verify #(
  parameter int NUM_ROUNDS = 12
) (
  input  logic                clk,
  input  logic                rst,
  ascon_final_verify_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [4:0][63:0] state_t;

  if (!(NUM_ROUNDS == 6 || NUM_ROUNDS == 8 || NUM_ROUNDS == 12)) begin : g_bad_rounds
    $error("ascon_final_verify: NUM_ROUNDS must be 6, 8 or 12");
  end

`ifdef ASCON_FINAL_UNROLL2_EN
  localparam logic [3:0] RND_STEP = 4'd2;
`else
  localparam logic [3:0] RND_STEP = 4'd1;
`endif
  localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS) - RND_STEP;
  localparam logic [3:0] RC_BASE  = 4'(12 - NUM_ROUNDS);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic state_t ascon_round(input state_t s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = 8'hF0 - 8'(idx) * 8'h0F;
    x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  state_t      s_q, s_d;
  logic [63:0] key0_q, key0_d, key1_q, key1_d;
  logic [63:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [63:0] t0_q, t0_d, t1_q, t1_d;
  logic        tag_ok_q, tag_ok_d;
  state_t      s_rnd;
  logic [3:0]  rc_idx;

  always_comb begin
    rc_idx = RC_BASE + rnd_q;
`ifdef ASCON_FINAL_UNROLL2_EN
    s_rnd = ascon_round(ascon_round(s_q, rc_idx), rc_idx + 4'd1);
`else
    s_rnd = ascon_round(s_q, rc_idx);
`endif
  end

  // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    s_d      = s_q;
    key0_d   = key0_q;
    key1_d   = key1_q;
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    tag_ok_d = tag_ok_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        s_d     = {bus.x4, bus.x3, bus.x2 ^ bus.key1, bus.x1 ^ bus.key0, bus.x0};
        key0_d  = bus.key0;
        key1_d  = bus.key1;
        tag0_d  = bus.tag0;
        tag1_d  = bus.tag1;
        rnd_d   = 4'd0;
        state_d = RUN;
      end
      RUN: begin
        s_d   = s_rnd;
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) begin
          t0_d     = s_rnd[3] ^ key0_q;
          t1_d     = s_rnd[4] ^ key1_q;
          // Full-width reduction: timing never depends on where the tags differ.
          tag_ok_d = ~|({t0_d, t1_d} ^ {tag0_q, tag1_q});
          state_d  = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        s_d      = '0;
        key0_d   = '0;
        key1_d   = '0;
        tag0_d   = '0;
        tag1_d   = '0;
        t0_d     = '0;
        t1_d     = '0;
        tag_ok_d = 1'b0;
        rnd_d    = 4'd0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so no key or tag material survives a reset.
      state_q  <= IDLE;
      rnd_q    <= 4'd0;
      s_q      <= '0;
      key0_q   <= '0;
      key1_q   <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      s_q      <= s_d;
      key0_q   <= key0_d;
      key1_q   <= key1_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      tag_ok_q <= tag_ok_d;
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE:    bus.in_ready  = ~rst;
      RUN:     bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.tag_ok = tag_ok_q;
  assign bus.t0     = t0_q;
  assign bus.t1     = t1_q;

endmodule

// File: tb/tb_ascon_final_verify.sv
// Self-checking bench for ascon_final_verify: three instances (12/8/6 rounds) against an array-based model.
module tb_ascon_final_verify;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        in_valid, out_ready;
  logic [63:0] x0, x1, x2, x3, x4, k0, k1, g0, g1;
  logic        m_in_ready, m_out_valid, m_tag_ok, m_busy;
  logic [63:0] m_t0, m_t1;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        rdy_a [3];
  logic        ov_a  [3];
  logic        ok_a  [3];
  logic        busy_a[3];
  logic [63:0] t0_a  [3];
  logic [63:0] t1_a  [3];

  always #5 clk = ~clk;

  ascon_final_verify_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NR = (g == 0) ? 12 : (g == 1) ? 8 : 6;
    assign bus[g].in_valid  = in_valid && (sel == g);
    assign bus[g].out_ready = out_ready && (sel == g);
    assign bus[g].x0   = x0;
    assign bus[g].x1   = x1;
    assign bus[g].x2   = x2;
    assign bus[g].x3   = x3;
    assign bus[g].x4   = x4;
    assign bus[g].key0 = k0;
    assign bus[g].key1 = k1;
    assign bus[g].tag0 = g0;
    assign bus[g].tag1 = g1;
    assign rdy_a[g]  = bus[g].in_ready;
    assign ov_a[g]   = bus[g].out_valid;
    assign ok_a[g]   = bus[g].tag_ok;
    assign busy_a[g] = bus[g].busy;
    assign t0_a[g]   = bus[g].t0;
    assign t1_a[g]   = bus[g].t1;
    ascon_final_verify #(.NUM_ROUNDS(NR)) u_dut (.clk(clk), .rst(rst), .bus(bus[g]));
  end

  always_comb begin
    m_in_ready  = rdy_a[sel];
    m_out_valid = ov_a[sel];
    m_tag_ok    = ok_a[sel];
    m_busy      = busy_a[sel];
    m_t0        = t0_a[sel];
    m_t1        = t1_a[sel];
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [127:0] model_tag(input logic [63:0] a0, a1, a2, a3, a4, ka, kb,
                                             input int nr);
    logic [63:0] x[5];
    logic [63:0] t[5];
    int          ra[5];
    int          rb[5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    x  = '{a0, a1 ^ ka, a2 ^ kb, a3, a4};
    for (int r = 0; r < nr; r++) begin
      x[2] = x[2] ^ 64'(240 - 15 * (12 - nr + r));
      x[0] = x[0] ^ x[4]; x[4] = x[4] ^ x[3]; x[2] = x[2] ^ x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
      x[1] = x[1] ^ x[0]; x[0] = x[0] ^ x[4]; x[3] = x[3] ^ x[2]; x[2] = ~x[2];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ rotr(x[i], ra[i]) ^ rotr(x[i], rb[i]);
    end
    return {x[3] ^ ka, x[4] ^ kb};
  endfunction

  function automatic int nr_of(input int s);
    return (s == 0) ? 12 : (s == 1) ? 8 : 6;
  endfunction

  function automatic int lat_of(input int nr);
`ifdef ASCON_FINAL_UNROLL2_EN
    return nr / 2;
`else
    return nr;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    x0 = {$urandom, $urandom}; x1 = {$urandom, $urandom}; x2 = {$urandom, $urandom};
    x3 = {$urandom, $urandom}; x4 = {$urandom, $urandom};
    k0 = {$urandom, $urandom}; k1 = {$urandom, $urandom};
    g0 = {$urandom, $urandom}; g1 = {$urandom, $urandom};
  endtask

  // Offers one job, then counts cycles from the accept edge to out_valid (-1 if it never comes).
  task automatic accept_and_wait(input bit toggle, output int lat);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    while (!m_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 40) begin
      if (toggle) begin
        randomize_inputs();
        in_valid = 1'($urandom_range(1, 0));
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    if (!m_out_valid) lat = -1;
  endtask

  task automatic release_result(input int stall);
    out_ready = 1'b0;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0; x4 = '0; k0 = '0; k1 = '0; g0 = '0; g1 = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (m_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready cyc%0d got %b want 0", i, m_in_ready); end
    end
    n_cmp++; if ({m_out_valid, m_tag_ok, m_busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got ov/ok/busy=%b want 000", {m_out_valid, m_tag_ok, m_busy});
    end
    n_cmp++; if ({m_t0, m_t1} !== 128'd0) begin n_bad++; $display("FAIL reset_tag got %h%h want 0", m_t0, m_t1); end
    rst = 1'b0;
    #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", m_in_ready); end
    tick();
  endtask

  task automatic test_golden();
    logic [127:0] exp_tag;
    int           lat;
    sel = 0;
    x0 = 64'h80400c0600000000; x1 = '0; x2 = '0; x3 = '0; x4 = '0; k0 = '0; k1 = '0;
    exp_tag  = model_tag(x0, x1, x2, x3, x4, k0, k1, 12);
    {g0, g1} = exp_tag;
    accept_and_wait(1'b0, lat);
    n_cmp++; if (lat != lat_of(12)) begin n_bad++; $display("FAIL golden_latency got %0d want %0d", lat, lat_of(12)); end
    n_cmp++; if ({m_t0, m_t1} !== exp_tag) begin n_bad++; $display("FAIL golden_tag got %h%h want %h", m_t0, m_t1, exp_tag); end
    n_cmp++; if (m_tag_ok !== 1'b1) begin n_bad++; $display("FAIL golden_tag_ok got %b want 1", m_tag_ok); end
    release_result(0);
  endtask

  task automatic test_tag_mismatch();
    logic [127:0] exp_tag;
    int           lat;
    sel = 0;
    x0 = 64'h80400c0600000000; x1 = '0; x2 = '0; x3 = '0; x4 = '0; k0 = '0; k1 = '0;
    exp_tag = model_tag(x0, x1, x2, x3, x4, k0, k1, 12);
    for (int v = 0; v < 2; v++) begin
      g0 = exp_tag[127:64] ^ ((v == 1) ? 64'h8000000000000000 : 64'd0);
      g1 = exp_tag[63:0]   ^ ((v == 0) ? 64'd1 : 64'd0);
      accept_and_wait(1'b0, lat);
      n_cmp++; if (m_tag_ok !== 1'b0) begin n_bad++; $display("FAIL flip%0d_tag_ok got %b want 0", v, m_tag_ok); end
      n_cmp++; if ({m_t0, m_t1} !== exp_tag) begin n_bad++; $display("FAIL flip%0d_tag got %h%h want %h", v, m_t0, m_t1, exp_tag); end
      release_result(0);
    end
  endtask

  task automatic test_hold();
    logic [127:0] exp_tag;
    int           lat;
    sel = 0;
    randomize_inputs();
    exp_tag  = model_tag(x0, x1, x2, x3, x4, k0, k1, 12);
    {g0, g1} = exp_tag;
    accept_and_wait(1'b0, lat);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({m_out_valid, m_tag_ok, m_in_ready} !== 3'b110 || {m_t0, m_t1} !== exp_tag) begin
        n_bad++; $display("FAIL hold_cyc%0d got ov/ok/rdy=%b tag=%h%h want 110 tag=%h",
                          i, {m_out_valid, m_tag_ok, m_in_ready}, m_t0, m_t1, exp_tag);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({m_out_valid, m_tag_ok, m_in_ready} !== 3'b001) begin
      n_bad++; $display("FAIL release_flags got ov/ok/rdy=%b want 001", {m_out_valid, m_tag_ok, m_in_ready});
    end
    n_cmp++; if ({m_t0, m_t1} !== 128'd0) begin n_bad++; $display("FAIL release_tag got %h%h want 0", m_t0, m_t1); end
  endtask

  task automatic test_abort();
    logic [127:0] exp_tag;
    int           lat;
    bit           seen;
    sel = 0;
    randomize_inputs();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", m_busy); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({m_out_valid, m_busy, m_in_ready} !== 3'b000) begin
      n_bad++; $display("FAIL abort_flags got ov/busy/rdy=%b want 000", {m_out_valid, m_busy, m_in_ready});
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle got in_ready=%b want 1", m_in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result got out_valid seen=%b want 0", seen); end
    randomize_inputs();
    exp_tag  = model_tag(x0, x1, x2, x3, x4, k0, k1, 12);
    {g0, g1} = exp_tag;
    accept_and_wait(1'b0, lat);
    n_cmp++; if ({m_t0, m_t1, m_tag_ok} !== {exp_tag, 1'b1} || lat != lat_of(12)) begin
      n_bad++; $display("FAIL abort_fresh_job got tag=%h%h ok=%b lat=%0d want tag=%h ok=1 lat=%0d",
                        m_t0, m_t1, m_tag_ok, lat, exp_tag, lat_of(12));
    end
    release_result(0);
  endtask

  task automatic test_random();
    logic [127:0] one;
    int           results;
    one     = 128'd1;
    results = 0;
    for (int j = 0; j < 100; j++) begin
      logic [127:0] exp_tag;
      logic         exp_ok;
      int           nr, lat;
      sel = $urandom_range(2, 0);
      nr  = nr_of(sel);
      randomize_inputs();
      exp_tag = model_tag(x0, x1, x2, x3, x4, k0, k1, nr);
      exp_ok  = 1'($urandom_range(1, 0));
      {g0, g1} = exp_ok ? exp_tag : (exp_tag ^ (one << $urandom_range(127, 0)));
      repeat ($urandom_range(3, 0)) tick();
      accept_and_wait(1'b1, lat);
      if (lat >= 0) results++;
      n_cmp++; if (lat != lat_of(nr)) begin n_bad++; $display("FAIL rand%0d_latency nr=%0d got %0d want %0d", j, nr, lat, lat_of(nr)); end
      n_cmp++; if ({m_t0, m_t1} !== exp_tag) begin n_bad++; $display("FAIL rand%0d_tag nr=%0d got %h%h want %h", j, nr, m_t0, m_t1, exp_tag); end
      n_cmp++; if (m_tag_ok !== exp_ok) begin n_bad++; $display("FAIL rand%0d_tag_ok nr=%0d got %b want %b", j, nr, m_tag_ok, exp_ok); end
      release_result($urandom_range(3, 0));
      n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_duplicate got out_valid=%b want 0", j, m_out_valid); end
    end
    n_cmp++; if (results != 100) begin n_bad++; $display("FAIL rand_result_count got %0d want 100", results); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_tag_mismatch();
    test_hold();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
